// File: rtl/uart_flash_pkg.sv
// uart_flash_pkg: shared state encoding and byte constants for the UART-to-flash frame path
package uart_flash_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_PROG, S_WAIT} state_t;
endpackage

// File: rtl/uart_frame_write_ctrl_if.sv
// uart_frame_write_ctrl_if: UART byte input, RAM write port and flash handshake for the frame controller
interface uart_frame_write_ctrl_if #(parameter int ADDR_W = 8);
    import uart_flash_pkg::*;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [BYTE_W-1:0] ram_wdata;
    logic              flash_start;
    logic [ADDR_W-1:0] flash_len;
    logic              flash_done;
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic              overrun;
    modport master (
        input  rx_valid, rx_data, flash_done,
        output ram_we, ram_addr, ram_wdata, flash_start, flash_len, busy, frame_done, frame_err, overrun
    );
    modport slave (
        output rx_valid, rx_data, flash_done,
        input  ram_we, ram_addr, ram_wdata, flash_start, flash_len, busy, frame_done, frame_err, overrun
    );
endinterface

// File: rtl/rx_gap_timer.sv
// rx_gap_timer: inter-byte gap counter that pulses expired when CYCLES-1 idle cycles have elapsed
module rx_gap_timer #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expired = run && !clear && cnt == CW'(CYCLES - 1);
    always_ff @(posedge clk)
        cnt <= (rst || clear || !run) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_frame_write_ctrl.sv
// uart_frame_write_ctrl: parses SOF/len/payload into RAM then requests one flash program; UART_FRAME_CHECKSUM_EN adds an XOR check byte
module uart_frame_write_ctrl
    import uart_flash_pkg::*;
#(
    parameter int                ADDR_W         = 8,
    parameter logic [BYTE_W-1:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int                TIMEOUT_CYCLES = 50000
) (
    input logic                    clk,
    input logic                    rst,
    uart_frame_write_ctrl_if.master bus
);
    state_t            state;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] idx;
    logic              expired;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0] xsum;
`endif

    // every accepted byte (and every state entry, which only happens on a byte) restarts the gap count
    rx_gap_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(bus.rx_valid),
        .run(state == S_LEN || state == S_DATA || state == S_CHK),
        .expired(expired)
    );

    assign bus.busy = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            len             <= '0;
            idx             <= '0;
            bus.ram_we      <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wdata   <= '0;
            bus.flash_start <= 1'b0;
            bus.flash_len   <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.overrun     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            xsum            <= '0;
`endif
        end else begin
            bus.ram_we      <= 1'b0;
            bus.flash_start <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            case (state)
                S_IDLE: if (bus.rx_valid && bus.rx_data == SOF_BYTE) state <= S_LEN;
                S_LEN: begin
                    if (expired) begin
                        bus.frame_err <= 1'b1;
                        state         <= S_IDLE;
                    end else if (bus.rx_valid) begin
                        len <= bus.rx_data[ADDR_W-1:0];
                        idx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        xsum <= '0;
`endif
                        bus.frame_err <= bus.rx_data[ADDR_W-1:0] == '0;
                        state         <= bus.rx_data[ADDR_W-1:0] == '0 ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (expired) begin
                        bus.frame_err <= 1'b1;
                        state         <= S_IDLE;
                    end else if (bus.rx_valid) begin
                        bus.ram_we    <= 1'b1;
                        bus.ram_addr  <= idx;
                        bus.ram_wdata <= bus.rx_data;
                        idx           <= idx + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                        xsum <= xsum ^ bus.rx_data;
                        if (idx + 1'b1 == len) state <= S_CHK;
`else
                        if (idx + 1'b1 == len) state <= S_PROG;
`endif
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                S_CHK: begin
                    if (expired) begin
                        bus.frame_err <= 1'b1;
                        state         <= S_IDLE;
                    end else if (bus.rx_valid) begin
                        bus.frame_err <= bus.rx_data != xsum;
                        state         <= bus.rx_data == xsum ? S_PROG : S_IDLE;
                    end
                end
`endif
                S_PROG: begin
                    bus.flash_start <= 1'b1;
                    bus.flash_len   <= len;
                    if (bus.rx_valid) bus.overrun <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.rx_valid) bus.overrun <= 1'b1;
                    if (bus.flash_done) begin
                        bus.frame_done <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_write_ctrl.sv
// tb_uart_frame_write_ctrl: directed frames with a write/flash scoreboard for uart_frame_write_ctrl
module tb_uart_frame_write_ctrl;
    localparam int TO = 40;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int passed = 0;
    int wr_cnt = 0;
    int flash_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    logic [15:0] wr_q[$];
    logic [7:0] len_q[$];

    always #5 clk = ~clk;

    uart_frame_write_ctrl_if #(.ADDR_W(8)) bus ();
    uart_frame_write_ctrl #(.ADDR_W(8), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.ram_we === 1'b1) begin
            wr_cnt++;
            check("unexpected_write", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) check("ram_addr_data", {bus.ram_addr, bus.ram_wdata}, wr_q.pop_front());
        end
        if (bus.flash_start === 1'b1) begin
            flash_cnt++;
            check("unexpected_flash", 32'(len_q.size() != 0), 32'd1);
            if (len_q.size() != 0) check("flash_len", bus.flash_len, len_q.pop_front());
        end
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] bytes[$], input bit expect_writes);
        for (int i = 0; i < bytes.size(); i++) begin
            if (expect_writes && i >= 2 && i < 2 + int'(bytes[1])) wr_q.push_back({8'(i - 2), bytes[i]});
            send(bytes[i]);
        end
    endtask

    task automatic finish_flash(input string tag);
        int d0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check({tag, "_busy_wait"}, bus.busy, 1'b1);
        bus.flash_done = 1'b1;
        @(negedge clk);
        bus.flash_done = 1'b0;
        check({tag, "_frame_done"}, bus.frame_done, 1'b1);
        check({tag, "_idle"}, bus.busy, 1'b0);
        @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    function automatic logic [31:0] outs();
        return {2'b0, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.flash_start, bus.flash_len,
                bus.busy, bus.frame_done, bus.frame_err, bus.overrun};
    endfunction

    initial begin
        int e0, f0, w0;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        bus.flash_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
        send(8'h3C);
        check("idle_discard", bus.busy, 1'b0);

        len_q.push_back(8'd3);
        frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}, 1);
        finish_flash("normal");
        check("normal_writes", wr_cnt, 3);

        e0 = err_cnt;
        frame('{8'hA5, 8'h00}, 1);
        check("zero_len_err", bus.frame_err, 1'b1);
        check("zero_len_idle", bus.busy, 1'b0);
        @(negedge clk);
        check("zero_len_err_once", err_cnt - e0, 1);
        len_q.push_back(8'd1);
        frame('{8'hA5, 8'h01, 8'h7E}, 1);
        finish_flash("after_zero");

        len_q.push_back(8'd2);
        frame('{8'hA5, 8'h02, 8'hA5, 8'h5A}, 1);
        finish_flash("sof_payload");
        check("flash_len_held", bus.flash_len, 8'd2);

        e0 = err_cnt;
        f0 = flash_cnt;
        frame('{8'hA5, 8'h04, 8'h01}, 1);
        repeat (TO - 3) @(negedge clk);
        check("timeout_not_early", err_cnt - e0, 0);
        check("timeout_busy", bus.busy, 1'b1);
        repeat (TO) @(negedge clk);
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_idle", bus.busy, 1'b0);
        check("timeout_no_flash", flash_cnt - f0, 0);

        len_q.push_back(8'd2);
        frame('{8'hA5, 8'h02, 8'hAA, 8'hBB}, 1);
        repeat (3) @(negedge clk);
        w0 = wr_cnt;
        send(8'h55);
        check("overrun_set", bus.overrun, 1'b1);
        finish_flash("overrun");
        check("overrun_sticky", bus.overrun, 1'b1);
        check("overrun_no_write", wr_cnt - w0, 0);

        frame('{8'hA5, 8'h05, 8'hC1, 8'hC2}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_data", outs(), 32'd0);
        rst = 1'b0;
        w0 = wr_cnt;
        f0 = flash_cnt;
        frame('{8'hC3, 8'hC4, 8'hC5}, 0);
        repeat (20) @(negedge clk);
        check("post_reset_no_write", wr_cnt - w0, 0);
        check("post_reset_no_flash", flash_cnt - f0, 0);
        check("post_reset_idle", bus.busy, 1'b0);

`ifdef UART_FRAME_CHECKSUM_EN
        len_q.push_back(8'd2);
        frame('{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFF}, 1);
        finish_flash("chk_match");
        e0 = err_cnt;
        f0 = flash_cnt;
        frame('{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00}, 1);
        repeat (15) @(negedge clk);
        check("chk_mismatch_err", err_cnt - e0, 1);
        check("chk_mismatch_no_flash", flash_cnt - f0, 0);
        check("chk_mismatch_idle", bus.busy, 1'b0);
`endif

        check("write_queue_drained", wr_q.size(), 0);
        check("flash_queue_drained", len_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_frame_write_ctrl.md
Name: uart_frame_write_ctrl

Overview:
- Sequences a UART byte stream into the staging RAM, then hands the buffered frame to the flash programmer.
- Parses each frame as start-of-frame byte, length byte, then payload. Payload bytes are written to RAM at addresses 0..L-1.
- Once the payload is complete, issues one flash-program request and waits for completion.
- Sits between the UART receiver and the RAM/flash-writer pair. Replaces free-running, rx-clocked address generation with a single-clock controller.

Parameters:
- ADDR_W, 8, RAM address width; maximum payload length is 2^ADDR_W-1.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle pulse per received UART byte.
- rx_data  in  8  received byte; valid when rx_valid=1.
- ram_we  out  1  RAM write strobe, one cycle per payload byte.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  8  RAM write data.
- flash_start  out  1  one-cycle request to the flash programmer.
- flash_len  out  ADDR_W  payload length, held stable from flash_start until flash_done.
- flash_done  in  1  one-cycle completion pulse from the flash programmer.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after flash_done is accepted.
- frame_err  out  1  one-cycle pulse on protocol error or timeout.
- overrun  out  1  sticky; set when a byte arrives in PROG or WAIT; cleared only by rst.

Behaviour:
- Reset values: every output is 0; state=IDLE; internal length register and timeout counter are 0.
- Synchronous rst overrides everything, including mid-frame and mid-WAIT; no flash_start may follow a reset.
- All outputs are registered; ram_we, ram_addr and ram_wdata appear the cycle after the accepting rx_valid.
- IDLE:
  - rx_valid with rx_data==SOF_BYTE -> LEN.
  - Any other byte is silently discarded.
- LEN:
  - On rx_valid, latch L=rx_data[ADDR_W-1:0].
  - L==0 -> frame_err pulse, go to IDLE.
  - L!=0 -> go to DATA with the write index at 0.
- DATA:
  - Each rx_valid writes the byte to the current index (ram_addr=index, ram_wdata=rx_data, ram_we=1), then increments the index.
  - After byte L-1 is written -> PROG.
  - A byte value equal to SOF_BYTE inside DATA is ordinary payload.
- PROG:
  - Lasts exactly one cycle.
  - Asserts flash_start=1 and drives flash_len=L, then goes to WAIT.
- WAIT:
  - On flash_done -> frame_done pulse, go to IDLE.
  - flash_done outside WAIT is ignored.
- Timeout:
  - Applies only in LEN and DATA.
  - The counter clears on every rx_valid and on state entry, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 -> frame_err pulse, go to IDLE; the partially written RAM is not cleared.
- rx_valid in PROG or WAIT: the byte is dropped and overrun is set.
- Same cycle as the transition into IDLE: an rx_valid is evaluated with IDLE rules on the next cycle only; a byte arriving on that same cycle is lost.
- Index arithmetic is ADDR_W bits; L ≤ 2^ADDR_W-1 guarantees no wrap-around.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined:
  - After the last payload byte, go to state CHK rather than PROG.
  - CHK expects one more byte equal to the XOR of all payload bytes; the timeout applies in CHK.
  - Match -> PROG.
  - Mismatch -> frame_err, go to IDLE, no flash_start.
  - The running XOR register resets on entry to LEN.
- Undefined: there is no CHK state and no XOR register; DATA goes straight to PROG.

Decomposition:
- Shared package uart_flash_pkg holds:
  - the state encoding enum (IDLE, LEN, DATA, CHK, PROG, WAIT);
  - the SOF_BYTE default constant;
  - the byte-width constant.
- One sub-module, rx_gap_timer: the clearable timeout counter.
  - Inputs: clk, rst, clear, run.
  - Output: a one-cycle expired pulse.

Test Plan:
- Normal frame: A5, 03, 11, 22, 33 -> RAM writes 0:11, 1:22, 2:33, each ram_we one cycle; then flash_start with flash_len=3. Drive flash_done 10 cycles later -> frame_done one cycle later, busy=0.
- Zero length: A5, 00 -> frame_err pulse, no ram_we, back in IDLE; a following A5, 01, 7E frame completes normally.
- Timeout: A5, 04, 01, then silence for TIMEOUT_CYCLES -> frame_err exactly once, state IDLE, flash_start never asserted.
- Overrun: during WAIT, send byte 55 -> overrun=1 and stays 1 after frame_done; no RAM write occurs.
- Reset mid-DATA: A5, 05, 2 bytes, rst for one cycle -> all outputs 0; sending the remaining 3 bytes produces no writes and no flash_start.
- Checksum (UART_FRAME_CHECKSUM_EN defined):
  - A5, 02, 0F, F0, FF -> flash_start.
  - A5, 02, 0F, F0, 00 -> frame_err, no flash_start.
